// File: rtl/cm0_acg_ctrl.sv
// Multi-channel architectural clock-gate controller: per-channel idle hold-off FSM,
// wake handshake and latch-based gate. Optional FORCEON input via CM0_ACG_CTRL_FORCEON_EN.
module cm0_acg_ctrl #(
  parameter int NCH  = 4,
  parameter int HOLD = 3,
  parameter int ACG  = 1
) (
  input  logic           FCLK,
  input  logic           HRESETn,
  input  logic           SE,
  input  logic [NCH-1:0] BUSY,
  input  logic [NCH-1:0] WAKEREQ,
`ifdef CM0_ACG_CTRL_FORCEON_EN
  input  logic [NCH-1:0] FORCEON,
`endif
  output logic [NCH-1:0] WAKEACK,
  output logic [NCH-1:0] CLKEN,
  output logic [NCH-1:0] GCLK,
  output logic [NCH-1:0] GATED,
  output logic           ALLGATED
);

  localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;

  logic [NCH-1:0] force_on;
  logic [NCH-1:0] clken;
  logic [NCH-1:0] wakeack_q;
  logic [NCH-1:0] wakeack_d;

`ifdef CM0_ACG_CTRL_FORCEON_EN
  assign force_on = FORCEON;
`else
  assign force_on = '0;
`endif

  assign wakeack_d = WAKEREQ;

  always_ff @(posedge FCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wakeack_q <= '0;
    end else begin
      wakeack_q <= wakeack_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic en_latch;

    if (ACG != 0) begin : g_fsm
      logic [1:0]    state_q;
      logic [1:0]    state_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          active;

      assign active = BUSY[gi] | WAKEREQ[gi] | force_on[gi];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_RUN: begin
            if (!active) begin
              if (HOLD == 0) begin
                state_d = ST_GATED;
              end else begin
                state_d = ST_HOLD;
                cnt_d   = CW'(HOLD);
              end
            end
          end
          ST_HOLD: begin
            // Returning to RUN here keeps CLKEN high throughout, so no edge is lost.
            if (active) begin
              state_d = ST_RUN;
            end else if (cnt_q == CW'(1)) begin
              state_d = ST_GATED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          ST_GATED: begin
            if (active) begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge FCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign clken[gi] = (state_q != ST_GATED);
    end else begin : g_nofsm
      assign clken[gi] = 1'b1;
    end

    // Transparent only while FCLK is low, so the enable is stable across the high phase.
    always_latch begin
      if (!FCLK) begin
        en_latch = clken[gi] | SE | (ACG == 0);
      end
    end

    assign GCLK[gi] = FCLK & en_latch;
  end

  assign WAKEACK  = wakeack_q;
  assign CLKEN    = clken;
  assign GATED    = ~clken;
  assign ALLGATED = &(~clken);

endmodule
